// File: rtl/nested_arb_pkg.sv
// ---------------------------------------------------------------------------
// nested_arb_pkg
//   Shared definitions for the nested round-robin arbiter slice.
//   - DEF_NUM_REQ / DEF_DATA_W : default requester count and data width
//   - arb_state_t              : output-register state (IDLE = empty,
//                                HOLD = holding a granted word)
// ---------------------------------------------------------------------------
package nested_arb_pkg;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_DATA_W  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage : nested_arb_pkg

// File: rtl/nested_rr_pick.sv
// ---------------------------------------------------------------------------
// nested_rr_pick
//   Combinational round-robin search. Finds the first set bit of req,
//   starting at index ptr and wrapping NUM_REQ-1 -> 0.
//
//   Ports
//     req    in   NUM_REQ          request vector
//     ptr    in   $clog2(NUM_REQ)  search start index (must be < NUM_REQ)
//     any    out  1                at least one request bit is set
//     winner out  $clog2(NUM_REQ)  index of the selected request
//                                  (0 when any is low)
// ---------------------------------------------------------------------------
module nested_rr_pick
  import nested_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SUM_W = PTR_W + 1;
  localparam logic [SUM_W-1:0] N_SUM = SUM_W'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;     // req rotated so that bit 0 is req[ptr]
  logic [PTR_W-1:0]   offset;  // distance from ptr to the winner
  logic [SUM_W-1:0]   sum;     // ptr + offset before the modulo fold

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    any    = 1'b0;
    offset = '0;
    winner = '0;

    // Rotating a doubled copy turns "search upward from ptr with wrap" into
    // a plain lowest-set-bit search starting at bit 0.
    rot = NUM_REQ'({req, req} >> ptr);
    any = |rot;

    // Scan high to low so the lowest set bit is the final assignment.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset = PTR_W'(k);
      end
    end

    // ptr and offset are both < NUM_REQ, so one conditional subtract is a
    // complete modulo.
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= N_SUM) begin
      winner = PTR_W'(sum - N_SUM);
    end else begin
      winner = PTR_W'(sum);
    end
  end

endmodule : nested_rr_pick

// File: rtl/nested_rr_arbiter.sv
// ---------------------------------------------------------------------------
// nested_rr_arbiter
//   Round-robin arbiter feeding a single registered output channel. Each
//   cycle the output register is free (empty, or being drained this cycle),
//   the first valid requester at or above the rotating pointer is accepted
//   and its word is presented on out_data the next cycle. Back-to-back
//   grants sustain one transfer per clock.
//
//   Ports
//     clk        in   1                single clock, rising edge
//     rst        in   1                synchronous, active-high reset
//     req_valid  in   NUM_REQ          per-requester data valid
//     req_data   in   NUM_REQ*DATA_W   requester i at [i*DATA_W +: DATA_W]
//     req_ready  out  NUM_REQ          one-hot (or zero) accept strobe
//     out_valid  out  1                output register holds a word
//     out_data   out  DATA_W           granted word
//     out_ready  in   1                downstream accepts out_data
//     grant_id   out  $clog2(NUM_REQ)  requester index of out_data
//     xfer_cnt   out  8                completed output transfers (wraps)
// ---------------------------------------------------------------------------
module nested_rr_arbiter
  import nested_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [7:0]                  xfer_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [PTR_W-1:0]   ptr;

  logic               pick_any;
  logic [PTR_W-1:0]   pick_winner;
  logic [PTR_W-1:0]   next_ptr;
  logic [DATA_W-1:0]  winner_data;
  logic               slot_free;   // output register can take a word now
  logic               load;
  logic               xfer;

  nested_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_winner)
  );

  assign out_valid = (state == HOLD);
  assign xfer      = out_valid && out_ready;
  assign slot_free = (state == IDLE) || out_ready;

  // Reset gates the accept so a requester never sees req_ready while its
  // word would be thrown away by the reset.
  assign load = !rst && slot_free && pick_any;

  assign winner_data = req_data[pick_winner*DATA_W +: DATA_W];
  assign next_ptr    = (pick_winner == PTR_W'(NUM_REQ - 1)) ? '0
                                                             : pick_winner + PTR_W'(1);

  always_comb begin
    req_ready = '0;
    if (load) begin
      req_ready[pick_winner] = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      out_data <= '0;
      grant_id <= '0;
      xfer_cnt <= '0;
    end else begin
      if (xfer) begin
        xfer_cnt <= xfer_cnt + 8'd1;
      end

      if (load) begin
        state    <= HOLD;
        out_data <= winner_data;
        grant_id <= pick_winner;
        ptr      <= next_ptr;
      end else if (xfer) begin
        // Drained with nothing waiting: the register goes empty. out_data
        // and grant_id keep their last value; they are ignored while
        // out_valid is low.
        state <= IDLE;
      end
    end
  end

  // Accept strobe is never more than one requester.
  assert property (@(posedge clk) $onehot0(req_ready));

  // A stalled word must not move or disappear.
  assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) && $stable(grant_id)));

endmodule : nested_rr_arbiter

// File: tb/tb_nested_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nested_rr_arbiter
//   Self-checking bench: a table of directed vectors, hand-written multi-cycle
//   sequences (reset mid-HOLD, round-robin order, backpressure, counter
//   wrap), then randomized traffic compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_nested_rr_arbiter;

  localparam int N  = 3;
  localparam int DW = 4;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_ready;
  logic [IW-1:0]     grant_id;
  logic [7:0]        xfer_cnt;

  nested_rr_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [N-1:0] v,
                       input logic [N*DW-1:0] d, input logic ordy);
    rst       = r;
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: an output slot that is full or empty, a rotating
  // start index, and a transfer count.
  // ---------------------------------------------------------------------
  int m_full, m_data, m_id, m_ptr, m_cnt;

  function automatic int model_pick(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (m_ptr + i) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_cycle(input logic r, input logic [N-1:0] v,
                             input logic [N*DW-1:0] d, input logic ordy,
                             input string tag);
    int           w;
    logic [N-1:0] er;
    drive(r, v, d, ordy);
    if (r || (m_full != 0 && !ordy)) w = -1;
    else                             w = model_pick(v);
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'(er));

    if (r) begin
      m_full = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (m_full != 0 && ordy) m_cnt = (m_cnt + 1) % 256;
      if (w >= 0) begin
        m_full = 1;
        m_data = int'(d[w*DW +: DW]);
        m_id   = w;
        m_ptr  = (w + 1) % N;
      end else if (m_full != 0 && ordy) begin
        m_full = 0;
      end
    end

    tick();
    check({tag, " out_valid"}, 32'(out_valid), 32'(m_full));
    check({tag, " xfer_cnt"},  32'(xfer_cnt),  32'(m_cnt));
    if (m_full != 0 || r) begin
      check({tag, " out_data"}, 32'(out_data), 32'(m_data));
      check({tag, " grant_id"}, 32'(grant_id), 32'(m_id));
    end
  endtask

  // ---------------------------------------------------------------------
  // Directed vector table. Expected outputs are the registered values seen
  // after the edge; e_ready is the combinational strobe before the edge.
  // ---------------------------------------------------------------------
  typedef struct {
    logic          rst;
    logic [N-1:0]  valid;
    logic [N*DW-1:0] data;
    logic          ordy;
    logic [N-1:0]  e_ready;
    logic          e_valid;
    logic [DW-1:0] e_data;
    int            e_id;
    int            e_cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 3'b000, 12'h000, 1'b0, 3'b000, 1'b0, 4'h0, 0, 0};
    vecs[1]  = '{1'b1, 3'b111, 12'h123, 1'b1, 3'b000, 1'b0, 4'h0, 0, 0};
    vecs[2]  = '{1'b0, 3'b010, 12'h0A0, 1'b1, 3'b010, 1'b1, 4'hA, 1, 0};
    vecs[3]  = '{1'b0, 3'b000, 12'h000, 1'b1, 3'b000, 1'b0, 4'h0, 0, 1};
    vecs[4]  = '{1'b0, 3'b001, 12'h003, 1'b0, 3'b001, 1'b1, 4'h3, 0, 1};
    vecs[5]  = '{1'b0, 3'b111, 12'h765, 1'b0, 3'b000, 1'b1, 4'h3, 0, 1};
    vecs[6]  = '{1'b0, 3'b111, 12'h765, 1'b1, 3'b010, 1'b1, 4'h6, 1, 2};
    vecs[7]  = '{1'b0, 3'b111, 12'h765, 1'b1, 3'b100, 1'b1, 4'h7, 2, 3};
    vecs[8]  = '{1'b0, 3'b111, 12'h765, 1'b1, 3'b001, 1'b1, 4'h5, 0, 4};
    vecs[9]  = '{1'b1, 3'b111, 12'h765, 1'b1, 3'b000, 1'b0, 4'h0, 0, 0};
    vecs[10] = '{1'b0, 3'b100, 12'h900, 1'b0, 3'b100, 1'b1, 4'h9, 2, 0};
    vecs[11] = '{1'b0, 3'b000, 12'h000, 1'b1, 3'b000, 1'b0, 4'h0, 0, 1};

    drive(1'b1, '0, '0, 1'b0);
    #1;

    // ---- table ----
    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].ordy);
      #1;
      check({tag, " req_ready"}, 32'(req_ready), 32'(vecs[i].e_ready));
      tick();
      check({tag, " out_valid"}, 32'(out_valid), 32'(vecs[i].e_valid));
      check({tag, " xfer_cnt"},  32'(xfer_cnt),  32'(vecs[i].e_cnt));
      if (vecs[i].e_valid || vecs[i].rst) begin
        check({tag, " out_data"}, 32'(out_data), 32'(vecs[i].e_data));
        check({tag, " grant_id"}, 32'(grant_id), 32'(vecs[i].e_id));
      end
    end

    // ---- reset held two cycles while a word is stalled in HOLD ----
    drive(1'b1, '0, '0, 1'b0);
    tick();
    drive(1'b0, 3'b100, 12'h500, 1'b0);
    tick();
    drive(1'b0, 3'b011, 12'h021, 1'b0);
    tick();
    check("hold before reset out_valid", 32'(out_valid), 32'd1);
    drive(1'b1, 3'b111, 12'h777, 1'b1);
    #1;
    check("rst cyc0 req_ready", 32'(req_ready), 32'd0);
    tick();
    check("rst cyc1 req_ready", 32'(req_ready), 32'd0);
    tick();
    drive(1'b0, 3'b000, 12'h000, 1'b0);
    #1;
    check("post rst out_valid", 32'(out_valid), 32'd0);
    check("post rst xfer_cnt",  32'(xfer_cnt),  32'd0);
    check("post rst grant_id",  32'(grant_id),  32'd0);
    check("post rst req_ready", 32'(req_ready), 32'd0);

    // ---- round robin with all requesters active, full throughput ----
    drive(1'b1, '0, '0, 1'b0);
    tick();
    drive(1'b0, 3'b111, 12'h321, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr%0d grant_id", k), 32'(grant_id),  32'(k % 3));
      check($sformatf("rr%0d out_data", k), 32'(out_data),  32'(k % 3 + 1));
      check($sformatf("rr%0d xfer_cnt", k), 32'(xfer_cnt),  32'(k));
    end

    // ---- backpressure: word 3 from requester 2 stalls for 5 cycles ----
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
      tick();
      check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d out_data", k),  32'(out_data),  32'd3);
      check($sformatf("bp%0d grant_id", k),  32'(grant_id),  32'd2);
      check($sformatf("bp%0d xfer_cnt", k),  32'(xfer_cnt),  32'd5);
    end
    out_ready = 1'b1;
    #1;
    check("bp release req_ready", 32'(req_ready), 32'b001);
    tick();
    check("bp release grant_id", 32'(grant_id), 32'd0);
    check("bp release xfer_cnt", 32'(xfer_cnt), 32'd6);

    // ---- transfer counter wrap ----
    drive(1'b1, '0, '0, 1'b0);
    tick();
    drive(1'b0, 3'b001, 12'h00F, 1'b1);
    for (int e = 1; e <= 258; e++) begin
      tick();
      if (e == 257) check("wrap 256 xfer_cnt", 32'(xfer_cnt), 32'd0);
      if (e == 258) check("wrap 257 xfer_cnt", 32'(xfer_cnt), 32'd1);
    end

    // ---- randomized traffic against the model ----
    m_full = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    model_cycle(1'b1, '0, '0, 1'b0, "rand reset");
    for (int c = 0; c < 1500; c++) begin
      logic          r;
      logic [N-1:0]  v;
      logic [N*DW-1:0] d;
      logic          o;
      r = ($urandom_range(0, 59) == 0);
      v = N'($urandom);
      if ($urandom_range(0, 4) == 0) v = '0;
      d = (N*DW)'($urandom);
      o = ($urandom_range(0, 3) != 0);
      model_cycle(r, v, d, o, $sformatf("rand%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nested_rr_arbiter
